wb_ram_arbiter: RTL
===================

Name: wb_ram_arbiter

Overview:
- Two-master round-robin Wishbone arbiter in front of one port of the dual-port system RAM.
- Lets the CPU data bus (m0) and a DMA/capture engine (m1) share one RAM port; the other RAM port stays dedicated to instruction fetch.
- Grant is held for a whole bus cycle (CYC high); masters are single-beat, pipelined-stall style, matching the RAM port's 1-cycle registered ACK and STALL.

Parameters:
- ADDR_WIDTH, 15, byte address width passed through to the RAM port.
- DATA_WIDTH, 32, data bus width in bits.
- SELECT_WIDTH, DATA_WIDTH/8, byte-select width.
- TIMEOUT_CYCLES, 255, watchdog limit in clocks; used only with WB_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active high
- m0_adr_i  in  ADDR_WIDTH  master 0 address
- m0_dat_i  in  DATA_WIDTH  master 0 write data
- m0_dat_o  out  DATA_WIDTH  master 0 read data
- m0_we_i, m0_stb_i, m0_cyc_i  in  1 each  master 0 write enable, strobe, cycle
- m0_sel_i  in  SELECT_WIDTH  master 0 byte selects
- m0_ack_o, m0_stall_o, m0_err_o  out  1 each  master 0 acknowledge, stall, error
- m1_*  same set as m0_*  master 1
- s_adr_o  out  ADDR_WIDTH  to RAM
- s_dat_o  out  DATA_WIDTH  to RAM
- s_dat_i  in  DATA_WIDTH  from RAM
- s_we_o, s_stb_o, s_cyc_o  out  1 each  to RAM
- s_sel_o  out  SELECT_WIDTH  to RAM
- s_ack_i, s_stall_i  in  1 each  from RAM

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values:
  - state = IDLE, last_grant = 1, so m0 wins the first tie.
  - All ack_o and err_o = 0; all m*_stall_o = 1 while rst_i is high.
  - s_cyc_o = s_stb_o = 0.
- States:
  - IDLE, GNT0, GNT1; registered. Only the state register and last_grant are registered; everything else is combinational from them.
  - IDLE -> GNT0 if m0_cyc_i and (!m1_cyc_i or last_grant==1).
  - IDLE -> GNT1 if m1_cyc_i and (!m0_cyc_i or last_grant==0).
  - GNTx -> IDLE when mx_cyc_i = 0; last_grant <= x on that transition.
  - No direct GNT0 <-> GNT1 transition: there is always at least one IDLE cycle between owners.
- Latency:
  - Grant appears on the clock edge after CYC is first seen.
  - RAM ACK arrives one cycle after an accepted STB. Minimum request-to-ACK is 2 clocks from IDLE.
- Muxing (combinational from state):
  - In GNTx: s_adr/dat/we/sel/stb/cyc_o = mx inputs; mx_dat_o = s_dat_i; mx_ack_o = s_ack_i; mx_stall_o = s_stall_i.
  - Non-granted master: ack_o = 0, stall_o = 1, dat_o = 0.
  - In IDLE: s_cyc_o = s_stb_o = 0 and both stall_o = 1.
- Handshake: a master may raise STB only while holding CYC. STB with stall_o = 1 is not accepted and must be held unchanged.
- Boundary cases:
  - Simultaneous request from IDLE: the master not granted last wins.
  - Master drops CYC in the same cycle as the ACK: the ACK is still delivered, then the arbiter goes to IDLE.
  - CYC dropped while an ACK is outstanding: the late s_ack_i is discarded, because state is IDLE and ack_o is 0.
  - Reset asserted mid-transfer: s_cyc_o/s_stb_o fall immediately and combinationally. Any pending RAM write may complete; no ACK reaches a master.
  - RAM stall (out-of-range address) is passed through unchanged. Without the timeout feature a master stuck on it stalls indefinitely.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit+ counter clears on every grant and on every s_ack_i, and increments every cycle in GNTx.
  - When it reaches TIMEOUT_CYCLES, mx_err_o pulses for 1 cycle and the state is forced to IDLE.
  - last_grant <= x, and s_cyc_o drops in that same cycle.
- Without the macro: m*_err_o are tied to 0 and no counter is synthesised.

Test Plan:
- Reset, then m0 write adr=0x10, dat=0xDEADBEEF, sel=4'hF -> s_cyc_o high 1 clk after CYC, m0_ack_o 1 clk after accepted STB. A following m0 read of 0x10 returns 0xDEADBEEF.
- m0 and m1 raise CYC on the same edge after reset -> m0 granted, m1_stall_o = 1. After m0 drops CYC: 1 IDLE cycle, then m1 granted.
- Repeat the simultaneous request with last_grant = 0 -> m1 granted first. Back-to-back contention over 8 rounds alternates grants m0,m1,m0,...
- m1 holds CYC across 4 pipelined reads 0x20..0x2C -> 4 ACKs in order with matching data, m0 fully stalled throughout, no m0 ack.
- rst_i pulsed mid-transfer while in GNT1 -> s_cyc_o = 0 within the same cycle, state IDLE, next simultaneous request granted to m0.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, m0 accesses adr beyond RAM size so s_stall_i stays 1 -> m0_err_o pulses at cycle 16 and the arbiter returns to IDLE. A pending m1 request is granted next.

Source files
------------

// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: two-master round-robin Wishbone arbiter for one RAM port.
// The CPU data bus (m0) and the DMA/capture engine (m1) share the port. A
// grant lasts for a whole bus cycle (CYC high), and there is always at least
// one IDLE cycle between owners. Masters are single-beat and pipelined, with
// STALL. The RAM supplies a 1-cycle registered ACK and a combinational STALL.
//
// Ports:
//   clk_i, rst_i       clock; asynchronous active-high reset
//   m0_* / m1_*        master-side Wishbone (adr/dat/we/sel/stb/cyc in,
//                      dat/ack/stall/err out)
//   s_*                RAM-side Wishbone (adr/dat/we/sel/stb/cyc out,
//                      dat/ack/stall in)
//
// Optional feature (macro WB_ARB_TIMEOUT_EN): a watchdog counts the cycles
// the current owner has held the bus without receiving an ACK. When the count
// reaches TIMEOUT_CYCLES, the arbiter pulses the owner's err_o, drops s_cyc_o
// in the same cycle and returns to IDLE. With the macro undefined, err_o is
// tied low and no counter is built.
module wb_ram_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 15,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  input  logic                    m0_we_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_cyc_i,
  input  logic [SELECT_WIDTH-1:0] m0_sel_i,
  output logic                    m0_ack_o,
  output logic                    m0_stall_o,
  output logic                    m0_err_o,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  input  logic                    m1_we_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_cyc_i,
  input  logic [SELECT_WIDTH-1:0] m1_sel_i,
  output logic                    m1_ack_o,
  output logic                    m1_stall_o,
  output logic                    m1_err_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  output logic                    s_we_o,
  output logic                    s_stb_o,
  output logic                    s_cyc_o,
  output logic [SELECT_WIDTH-1:0] s_sel_o,
  input  logic                    s_ack_i,
  input  logic                    s_stall_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   timeout;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter is zero in the first granted cycle, so it fires in the
  // TIMEOUT_CYCLES-th consecutive granted cycle that has no ACK.
  always_comb begin
    cnt_d   = '0;
    timeout = 1'b0;
    if (state_q != IDLE) begin
      timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
      if (!s_ack_i && !timeout) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        // On a tie, the master that was not granted last wins.
        if (m0_cyc_i && (!m1_cyc_i || last_grant_q)) begin
          state_d = GNT0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i || timeout) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
        end
      end
      GNT1: begin
        if (!m1_cyc_i || timeout) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The asynchronous reset forces state_q to IDLE at once, which makes
  // s_cyc_o/s_stb_o fall and both stalls rise combinationally.
  always_comb begin
    s_adr_o    = '0;
    s_dat_o    = '0;
    s_we_o     = 1'b0;
    s_sel_o    = '0;
    s_stb_o    = 1'b0;
    s_cyc_o    = 1'b0;
    m0_dat_o   = '0;
    m0_ack_o   = 1'b0;
    m0_stall_o = 1'b1;
    m0_err_o   = 1'b0;
    m1_dat_o   = '0;
    m1_ack_o   = 1'b0;
    m1_stall_o = 1'b1;
    m1_err_o   = 1'b0;
    unique case (state_q)
      GNT0: begin
        s_adr_o    = m0_adr_i;
        s_dat_o    = m0_dat_i;
        s_we_o     = m0_we_i;
        s_sel_o    = m0_sel_i;
        s_stb_o    = m0_stb_i && !timeout;
        s_cyc_o    = m0_cyc_i && !timeout;
        m0_dat_o   = s_dat_i;
        m0_ack_o   = s_ack_i;
        m0_stall_o = s_stall_i || timeout;
        m0_err_o   = timeout;
      end
      GNT1: begin
        s_adr_o    = m1_adr_i;
        s_dat_o    = m1_dat_i;
        s_we_o     = m1_we_i;
        s_sel_o    = m1_sel_i;
        s_stb_o    = m1_stb_i && !timeout;
        s_cyc_o    = m1_cyc_i && !timeout;
        m1_dat_o   = s_dat_i;
        m1_ack_o   = s_ack_i;
        m1_stall_o = s_stall_i || timeout;
        m1_err_o   = timeout;
      end
      default: ;
    endcase
  end

endmodule
